// File: rtl/demux_pkg.sv
// Shared types and constants for the two-lane interleaved-link demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    EXP0 = 2'b01,
    EXP1 = 2'b10
  } state_e;

  localparam int ERR_CNT_W   = 8;
  localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/demux_sat_counter.sv
// Saturating event counter, 1-cycle update latency, cleared only by async reset.
// No backpressure: every inc pulse is counted until the ceiling is reached.
module sat_counter
  import demux_pkg::*;
#(
  parameter int W   = ERR_CNT_W,
  parameter int MAX = ERR_CNT_MAX
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != MAX_V)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/demux.sv
// Splits the alternating lane-0/lane-1 word stream back into two registered lanes; 1-cycle latency,
// no backpressure (every valid word is consumed). DEMUX_ERR_CNT_EN adds the saturating err_cnt port.
module demux
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic             valid_out_0,
  output logic             valid_out_1,
  output logic             pair_valid,
  output logic             locked,
  output logic             align_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             vo0_q, vo0_d;
  logic             vo1_q, vo1_d;
  logic             pair_q, pair_d;
  logic             locked_q, locked_d;
  logic             align_err_q, align_err_d;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // A slip re-anchors on the new lane-0 word, so EXP1 is held rather than left.
  always_comb begin
    state_d = state_q;
    if (valid_in) begin
      case (state_q)
        HUNT:    if (sof_in) state_d = EXP1;
        EXP1:    if (!sof_in) state_d = EXP0;
        EXP0:    state_d = EXP1;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    data0_d     = data0_q;
    data1_d     = data1_q;
    vo0_d       = 1'b0;
    vo1_d       = 1'b0;
    pair_d      = 1'b0;
    align_err_d = 1'b0;
    locked_d    = locked_q;
    if (valid_in) begin
      case (state_q)
        HUNT: begin
          if (sof_in) begin
            data0_d  = data_in;
            vo0_d    = 1'b1;
            locked_d = 1'b1;
          end
        end
        EXP1: begin
          if (sof_in) begin
            data0_d     = data_in;
            vo0_d       = 1'b1;
            align_err_d = 1'b1;
          end else begin
            data1_d = data_in;
            vo1_d   = 1'b1;
            pair_d  = 1'b1;
          end
        end
        EXP0: begin
          data0_d = data_in;
          vo0_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data0_q     <= '0;
      data1_q     <= '0;
      vo0_q       <= 1'b0;
      vo1_q       <= 1'b0;
      pair_q      <= 1'b0;
      locked_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      vo0_q       <= vo0_d;
      vo1_q       <= vo1_d;
      pair_q      <= pair_d;
      locked_q    <= locked_d;
      align_err_q <= align_err_d;
    end
  end

  assign data_out_0  = data0_q;
  assign data_out_1  = data1_q;
  assign valid_out_0 = vo0_q;
  assign valid_out_1 = vo1_q;
  assign pair_valid  = pair_q;
  assign locked      = locked_q;
  assign align_err   = align_err_q;

`ifdef DEMUX_ERR_CNT_EN
  // Fed from the next-state pulse so the count moves in the same cycle align_err shows.
  sat_counter #(
    .W   (ERR_CNT_W),
    .MAX (ERR_CNT_MAX)
  ) u_err_cnt (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (align_err_d),
    .cnt     (err_cnt)
  );
`endif

endmodule

// File: tb/tb_demux.sv
// Scoreboarded bench for demux: directed words push expected output records, a negedge monitor pops them.
module tb_demux;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_L;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         sof_in;
  logic [W-1:0] data_out_0;
  logic [W-1:0] data_out_1;
  logic         valid_out_0;
  logic         valid_out_1;
  logic         pair_valid;
  logic         locked;
  logic         align_err;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  demux #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .sof_in      (sof_in),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .pair_valid  (pair_valid),
    .locked      (locked),
    .align_err   (align_err)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  typedef struct packed {
    logic       vo0;
    logic       vo1;
    logic       pv;
    logic       ae;
    logic       lk;
    logic [3:0] d0;
    logic [3:0] d1;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Expected record for one accepted word; locked is 1 whenever any pulse is expected.
  task automatic push_exp(input logic vo0, input logic vo1, input logic pv, input logic ae,
                          input logic [3:0] d0, input logic [3:0] d1);
    obs_t e;
    e = '{vo0: vo0, vo1: vo1, pv: pv, ae: ae, lk: 1'b1, d0: d0, d1: d1};
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    valid_in = v;
    sof_in   = s;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  initial begin : monitor
    obs_t act;
    forever begin
      @(negedge clk);
      act = {valid_out_0, valid_out_1, pair_valid, align_err, locked, data_out_0, data_out_1};
      if (valid_out_0 | valid_out_1 | pair_valid | align_err) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h expected no pulse", act);
        end else begin
          chk("out_word", act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_L  = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    data_in  = '0;

    // Reset holds everything low regardless of input activity.
    for (int i = 0; i < 4; i++) begin
      data_in  = 4'($urandom);
      valid_in = 1'($urandom);
      sof_in   = 1'($urandom);
      @(negedge clk);
      chk("reset_state",
          {data_out_0, data_out_1, valid_out_0, valid_out_1, pair_valid, align_err, locked}, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    sof_in   = 1'b0;
    reset_L  = 1'b1;
    @(posedge clk);
    #1;

    // Acquisition: non-sof words dropped while hunting.
    drive(1, 0, 4'h3);
    drive(1, 0, 4'h6);
    chk("hunt_unlocked", locked, 0);
    push_exp(1, 0, 0, 0, 4'hA, 4'h0);
    drive(1, 1, 4'hA);
    push_exp(0, 1, 1, 0, 4'hA, 4'h5);
    drive(1, 0, 4'h5);

    // Idle gap between lanes: outputs hold, pair still forms.
    push_exp(1, 0, 0, 0, 4'h1, 4'h5);
    drive(1, 1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'hF);
      chk("gap_hold", {data_out_0, data_out_1}, {4'h1, 4'h5});
    end
    push_exp(0, 1, 1, 0, 4'h1, 4'h2);
    drive(1, 0, 4'h2);

    // Phase slip while expecting lane 1.
    push_exp(1, 0, 0, 0, 4'hB, 4'h2);
    drive(1, 1, 4'hB);
    push_exp(1, 0, 0, 1, 4'hC, 4'h2);
    drive(1, 1, 4'hC);
    chk("slip_keeps_lock", locked, 1);
    push_exp(0, 1, 1, 0, 4'hC, 4'hD);
    drive(1, 0, 4'hD);

    // Lane 0 without sof once locked.
    push_exp(1, 0, 0, 0, 4'hE, 4'hD);
    drive(1, 0, 4'hE);
    push_exp(0, 1, 1, 0, 4'hE, 4'hF);
    drive(1, 0, 4'hF);

    // Async reset mid-pair, asserted away from any clock edge.
    push_exp(1, 0, 0, 0, 4'h7, 4'hF);
    drive(1, 1, 4'h7);
    @(negedge clk);
    #1;
    reset_L = 1'b0;
    #1;
    chk("async_clear",
        {data_out_0, data_out_1, valid_out_0, valid_out_1, pair_valid, align_err, locked}, 0);
    @(posedge clk);
    #3;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 4'h9);
    chk("post_reset_drop_lock", locked, 0);
    chk("post_reset_drop_data", data_out_0, 0);
    push_exp(1, 0, 0, 0, 4'h4, 4'h0);
    drive(1, 1, 4'h4);

`ifdef DEMUX_ERR_CNT_EN
    chk("err_cnt_after_reset", err_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] dd;
      dd = 4'(i);
      push_exp(1, 0, 0, 1, dd, 4'h0);
      drive(1, 1, dd);
      if (i == 9) chk("err_cnt_10", err_cnt, 10);
    end
    drive(0, 0, 4'h0);
    drive(0, 0, 4'h0);
    chk("err_cnt_saturated", err_cnt, 255);
`endif

    drive(0, 0, 4'h0);
    drive(0, 0, 4'h0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
